pipe_width_packer: RTL



---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_width_packer_if.sv | 40 ++++
 rtl/pipe_out_reg.sv | 41 ++++
 rtl/pipe_width_packer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: items shared by the middle pipe stage and its width packer.
//   PIPE_DW / PIPE_RATIO : default beat width and beats per packed word
//   packer_state_e       : packer state machine encoding
//   cnt_width()          : width of a 0..ratio beat count
package pipe_pkg;

  localparam int unsigned PIPE_DW    = 1;
  localparam int unsigned PIPE_RATIO = 4;

  typedef enum logic {
    FILL       = 1'b0,
    FLUSH_PEND = 1'b1
  } packer_state_e;

  // Bits needed to hold a count from 0 to ratio inclusive.
  function automatic int unsigned cnt_width(input int unsigned ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/pipe_width_packer_if.sv
// pipe_width_packer_if: beat input stream and packed word output stream of the
// width packer, bundled together.
//   master : beat producer / word consumer (drives DataIn*, Flush, DataOutRdy)
//   slave  : the packer (drives DataInRdy, DataOut*, DataOutVld)
// Flush is present only when PACKER_FLUSH_EN is defined.
interface pipe_width_packer_if #(
  parameter int unsigned DW    = pipe_pkg::PIPE_DW,
  parameter int unsigned RATIO = pipe_pkg::PIPE_RATIO
);

  localparam int unsigned CW = pipe_pkg::cnt_width(RATIO);

  logic [DW-1:0]       DataIn;
  logic                DataInVld;
  logic                DataInRdy;
`ifdef PACKER_FLUSH_EN
  logic                Flush;
`endif
  logic [DW*RATIO-1:0] DataOut;
  logic [CW-1:0]       DataOutCnt;
  logic                DataOutVld;
  logic                DataOutRdy;

  modport master (
`ifdef PACKER_FLUSH_EN
    output Flush,
`endif
    output DataIn, DataInVld, DataOutRdy,
    input  DataInRdy, DataOut, DataOutCnt, DataOutVld
  );

  modport slave (
`ifdef PACKER_FLUSH_EN
    input  Flush,
`endif
    input  DataIn, DataInVld, DataOutRdy,
    output DataInRdy, DataOut, DataOutCnt, DataOutVld
  );

endinterface

// File: rtl/pipe_out_reg.sv
// pipe_out_reg: valid/ready holding register for a data word plus beat count.
//   clk, rst_n          : clock, async active-low reset
//   load                : capture load_data/load_cnt (only raised while free_c)
//   load_data, load_cnt : word and count to capture
//   rdy                 : consumer ready
//   free_c              : register can take a new word this cycle (combinational)
//   data, cnt, vld      : registered output word, count and valid
module pipe_out_reg #(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic [CW-1:0] load_cnt,
  input  logic          rdy,
  output logic          free_c,
  output logic [W-1:0]  data,
  output logic [CW-1:0] cnt,
  output logic          vld
);

  assign free_c = !vld || rdy;

  // A load during a drain replaces the word and keeps vld high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      cnt  <= '0;
      vld  <= 1'b0;
    end else if (load) begin
      data <= load_data;
      cnt  <= load_cnt;
      vld  <= 1'b1;
    end else if (vld && rdy) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_width_packer.sv
// pipe_width_packer: packs RATIO consecutive DW-bit beats into one DW*RATIO-bit
// word (beat 0 in the low bits), one beat per cycle with no word-boundary bubble.
//   Clk, Rstn : clock, async active-low reset
//   bus       : pipe_width_packer_if slave (beat stream in, packed word out)
// Build option PACKER_FLUSH_EN: adds the Flush request, the FLUSH_PEND state and
// partial-word emission; without it only full words are emitted.
module pipe_width_packer
  import pipe_pkg::*;
#(
  parameter int unsigned DW    = PIPE_DW,
  parameter int unsigned RATIO = PIPE_RATIO
) (
  input logic               Clk,
  input logic               Rstn,
  pipe_width_packer_if.slave bus
);

  localparam int unsigned CW   = cnt_width(RATIO);
  localparam int unsigned CNTW = $clog2(RATIO);
  localparam int unsigned SW   = DW * (RATIO - 1);
  localparam int unsigned OW   = DW * RATIO;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(RATIO - 1);

  logic [CNTW-1:0] cnt;
  logic [SW-1:0]   slots;
  logic            free_c;
  logic            accept_c;
  logic            last_c;
  logic            load_c;
  logic [OW-1:0]   load_data_c;
  logic [CW-1:0]   load_cnt_c;

  assign last_c   = (cnt == CNT_LAST);
  assign accept_c = bus.DataInVld && bus.DataInRdy;

`ifdef PACKER_FLUSH_EN
  packer_state_e state;
  logic [SW-1:0] merged_c;
  logic [CW-1:0] held_c;
  logic [OW-1:0] partial_c;
  logic          full_c;
  logic          flush_now_c;

  // Slots and beat count as they stand once this cycle's beat (if any) is
  // included; the partial word masks slots past the count so stale beats
  // from earlier words never leak out.
  always_comb begin
    merged_c = slots;
    if (accept_c && !last_c) merged_c[int'(cnt)*DW +: DW] = bus.DataIn;
    held_c    = CW'(cnt) + CW'(accept_c);
    partial_c = '0;
    for (int unsigned i = 0; i < RATIO - 1; i++) begin
      if (CW'(i) < held_c) partial_c[i*DW +: DW] = merged_c[i*DW +: DW];
    end
  end

  assign full_c        = accept_c && last_c;
  assign flush_now_c   = (state == FILL) && bus.Flush && !full_c && (held_c != '0);
  assign bus.DataInRdy = (state == FILL) && (!last_c || free_c);
  assign load_c        = full_c || (flush_now_c && free_c) ||
                         ((state == FLUSH_PEND) && free_c);
  assign load_data_c   = full_c ? {bus.DataIn, slots} : partial_c;
  assign load_cnt_c    = full_c ? CW'(RATIO) : held_c;

  // Accumulator, counter and flush state machine.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state <= FILL;
      cnt   <= '0;
      slots <= '0;
    end else begin
      case (state)
        FILL: begin
          slots <= merged_c;
          if (full_c) begin
            cnt <= '0;
          end else if (flush_now_c) begin
            if (free_c) begin
              cnt <= '0;
            end else begin
              cnt   <= CNTW'(held_c);
              state <= FLUSH_PEND;
            end
          end else begin
            cnt <= CNTW'(held_c);
          end
        end
        FLUSH_PEND: begin
          if (free_c) begin
            cnt   <= '0;
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
`else
  assign bus.DataInRdy = !last_c || free_c;
  assign load_c        = accept_c && last_c;
  assign load_data_c   = {bus.DataIn, slots};
  assign load_cnt_c    = CW'(RATIO);

  // Accumulator and counter; the final beat goes straight to the output.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      cnt   <= '0;
      slots <= '0;
    end else if (accept_c) begin
      if (last_c) begin
        cnt <= '0;
      end else begin
        slots[int'(cnt)*DW +: DW] <= bus.DataIn;
        cnt                       <= cnt + 1'b1;
      end
    end
  end
`endif

  pipe_out_reg #(
    .W  (OW),
    .CW (CW)
  ) u_out_reg (
    .clk       (Clk),
    .rst_n     (Rstn),
    .load      (load_c),
    .load_data (load_data_c),
    .load_cnt  (load_cnt_c),
    .rdy       (bus.DataOutRdy),
    .free_c    (free_c),
    .data      (bus.DataOut),
    .cnt       (bus.DataOutCnt),
    .vld       (bus.DataOutVld)
  );

endmodule
